// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// op codes, FSM states, iteration count and two's-complement helpers.
package mips_pkg;

    localparam int XLEN     = 32;
    localparam int MD_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? negate(v) : v;
    endfunction

endpackage

// File: rtl/multdiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO: shift-add multiply,
// restoring divide, sign correction in a final FIX cycle.
module multdiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_e        dbg_state
);

    // Handshake: start is sampled only in IDLE (it beats a same-edge MTHI/MTLO);
    // busy covers CALC and FIX; done pulses one cycle once HI/LO hold the result,
    // and start held during that cycle launches the next operation.
    localparam int CW = $clog2(MD_ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(MD_ITERS - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_neg;
    logic               op_is_div;

    // Multiply: acc_lo starts as the multiplier; divide: acc_lo starts as the dividend
    // and collects quotient bits while acc_hi carries the partial remainder.
    assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};
    assign prod_neg  = ~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1);
    assign op_is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    op_d      = md_op_e'(op);
                    opnd_d    = op[1] ? magnitude(b, op[0]) : magnitude(a, op[0]);
                    acc_hi_d  = '0;
                    acc_lo_d  = op[1] ? magnitude(a, op[0]) : magnitude(b, op[0]);
                    // A zero divisor must leave the all-ones quotient unnegated.
                    neg_res_d = op[0] && (a[WIDTH-1] ^ b[WIDTH-1]) && !(op[1] && (b == '0));
                    neg_rem_d = op[0] && a[WIDTH-1];
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            CALC: begin
                if (op_is_div) begin
                    acc_hi_d = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {add_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_is_div) begin
                    lo_d = neg_res_q ? negate(acc_lo_q) : acc_lo_q;
                    hi_d = neg_rem_q ? negate(acc_hi_q) : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : {acc_hi_q, acc_lo_q};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULTU;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: randomized and directed MULT/DIV/MTHI/MTLO traffic
// checked against an arithmetic reference model and an expected-result queue.
module tb_multdiv_unit;
    import mips_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: {HI, LO} straight from integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            2'b00: res = {32'd0, x} * {32'd0, y};
            2'b01: res = 64'(sx * sy);
            2'b10: res = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit with_wr);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (with_wr) begin
            wr_hi = 1'b1; wr_lo = 1'b1; wdata = $urandom;
        end
        exp_q.push_back(ref_md(o, x, y));
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Called #1 after the start edge; optionally pokes start+writes at cycle poke_at
    // and optionally holds start through the done cycle to chain the next op.
    task automatic wait_done(input string name, input int poke_at, input bit chain,
                             input logic [1:0] nop, input logic [31:0] na, input logic [31:0] nb);
        int lat = 0;
        int busy_n = 0;
        bit stable = 1'b1;
        logic [63:0] exp;
        if (busy === 1'b1) busy_n++;
        if (hi !== model_hi || lo !== model_lo) stable = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) busy_n++;
            if (hi !== model_hi || lo !== model_lo) stable = 1'b0;
            if (start) begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            if (k == poke_at) begin
                start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wdata = $urandom;
                op = 2'($urandom); a = $urandom; b = $urandom;
            end
        end
        total_cnt++;
        if (lat !== 33) $display("FAIL %s latency: got %0d edges after start, expected 33", name, lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_n !== 33) $display("FAIL %s busy_cycles: got %0d, expected 33", name, busy_n);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b, expected 0", name, busy);
        else pass_cnt++;
        total_cnt++;
        if (!stable) $display("FAIL %s hilo_stable: HI/LO moved during operation, expected %h/%h", name, model_hi, model_lo);
        else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        total_cnt++;
        if ({hi, lo} !== exp) $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
        else pass_cnt++;
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        if (chain) begin
            start = 1'b1; op = nop; a = na; b = nb;
            exp_q.push_back(ref_md(nop, na, nb));
        end
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL %s done_width: got done=%b one cycle later, expected 0", name, done);
        else pass_cnt++;
        if (chain) begin
            start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL %s chained_accept: got busy=%b, expected 1", name, busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_ctrl: got busy=%b done=%b, expected 0/0", busy, done);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo: got hi=%h lo=%h, expected 0/0", hi, lo);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d, expected IDLE", dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        @(negedge clk); wr_hi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1; wr_hi = 1'b0; model_hi = 32'h1234_5678;
        total_cnt++;
        if (hi !== model_hi || lo !== model_lo) $display("FAIL mthi: got hi=%h lo=%h, expected %h/%h", hi, lo, model_hi, model_lo);
        else pass_cnt++;
        v = $urandom;
        @(negedge clk); wr_lo = 1'b1; wdata = v;
        @(posedge clk); #1; wr_lo = 1'b0; model_lo = v;
        total_cnt++;
        if (hi !== model_hi || lo !== model_lo) $display("FAIL mtlo: got hi=%h lo=%h, expected %h/%h", hi, lo, model_hi, model_lo);
        else pass_cnt++;
        v = $urandom;
        @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = v;
        @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0; model_hi = v; model_lo = v;
        total_cnt++;
        if (hi !== model_hi || lo !== model_lo) $display("FAIL mthi_mtlo_both: got hi=%h lo=%h, expected %h/%h", hi, lo, model_hi, model_lo);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu_max", 0, 1'b0, 2'b00, 32'd0, 32'd0);
        total_cnt++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) $display("FAIL multu_max_const: got hi=%h lo=%h, expected fffffffe/00000001", hi, lo);
        else pass_cnt++;
        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done("mult_neg_collide_wr", 0, 1'b0, 2'b00, 32'd0, 32'd0);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg7_by2", 0, 1'b0, 2'b00, 32'd0, 32'd0);
        issue(2'b10, 32'd7, 32'd0, 1'b0);
        wait_done("divu_by_zero", 0, 1'b0, 2'b00, 32'd0, 32'd0);
        issue(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);
        wait_done("div_neg_by_zero", 0, 1'b0, 2'b00, 32'd0, 32'd0);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div_overflow", 0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic test_start_while_busy();
        issue(2'b00, 32'd3, 32'd4, 1'b0);
        wait_done("multu_repulse", 10, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        issue(2'b10, $urandom, 32'($urandom_range(1, 1000)), 1'b0);
        wait_done("b2b_first", 0, 1'b1, 2'b01, $urandom, $urandom);
        wait_done("b2b_second", 0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 16));
                3: x = 32'($urandom_range(0, 100));
                default: ;
            endcase
            issue(o, x, y, 1'b0);
            wait_done("random_op", 0, 1'b0, 2'b00, 32'd0, 32'd0);
        end
    endtask

    task automatic test_reset_mid_op();
        bit saw_done = 1'b0;
        @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5_0001;
        @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;
        issue(2'b10, $urandom, 32'($urandom_range(1, 255)), 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        reset = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_ctrl: got busy=%b done=%b, expected 0/0", busy, done);
        else pass_cnt++;
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL midreset_hilo: got hi=%h lo=%h, expected 0/0", hi, lo);
        else pass_cnt++;
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1 || hi !== 32'd0 || lo !== 32'd0) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done) $display("FAIL midreset_quiet: got a done/busy/HI-LO change after abort, expected none");
        else pass_cnt++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); reset = 1'b1;
        test_mthi_mtlo();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
